aes192_key_sched_rev: RTL and testbench
=======================================

# aes192_key_sched_rev

Iterative AES-192 key-expansion unit that feeds the decryption side of the AES-192 encrypt/decrypt wrapper. It expands a 192-bit cipher key into the 52-word schedule and streams the 13 round keys in reverse order (round 12 down to 0) over a valid/ready interface. This is the order the inverse cipher consumes them, the mirror of the forward order the encryptor uses. Key words are computed one per cycle and buffered internally, so the decryptor never stalls on key generation mid-block.

## Interface
- No parameters. Sizes are fixed by AES-192: Nk=6, Nr=12, 52 words.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  request expansion; sampled only in IDLE
- key_in  in  192  cipher key; key_in[191:160] is w[0]
- busy  out  1  high from the cycle after start is accepted until done
- rk_valid  out  1  round key available on rk_out
- rk_ready  in  1  consumer accepts rk_out when rk_valid & rk_ready
- rk_out  out  128  round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96]
- rk_index  out  4  round number r of the key currently on rk_out
- rk_last  out  1  high with rk_valid on the final key of the stream
- done  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states are IDLE, EXPAND, STREAM, DONE.
- IDLE
  - On start=1, latch key_in into w[0..5], set word counter i=6 and go to EXPAND.
- EXPAND
  - Compute one word per cycle: temp = w[i-1].
  - If i mod 6 == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/6], 24'h0}, with Rcon[1..8] = 01,02,04,08,10,20,40,80.
  - w[i] = w[i-6] ^ temp.
  - SubWord uses four instances of the team's forward S-box.
  - After w[51] is written, set r=12 and go to STREAM.
- STREAM
  - rk_valid=1. rk_out and rk_index reflect r.
  - On each handshake: if r==0 go to DONE, else r=r-1.
  - rk_last = (r==0).
- DONE
  - done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE; no queuing.
- All 8-bit Rcon and S-box arithmetic is in GF(2^8). XORs are bitwise, 32-bit.

## Timing
- Reset values: busy=0, rk_valid=0, rk_out=0, rk_index=0, rk_last=0, done=0. State returns to IDLE.
- Reset has priority over start and over any handshake in the same cycle.
- Reset mid-EXPAND or mid-STREAM aborts the operation. No done pulse; the word buffer contents are don't-care.
- start accepted at edge N:
  - busy=1 from cycle N+1.
  - Expansion takes 46 cycles: w[6..51].
  - First rk_valid=1 in cycle N+47.
- With rk_ready held at 1, the 13 keys transfer in 13 consecutive cycles. done pulses in the cycle after the rk_last handshake.
- busy drops in the same cycle done rises.
- While rk_valid & !rk_ready: rk_out, rk_index and rk_last hold stable.
- rk_valid never deasserts before its handshake.
- A new start may be accepted in the cycle after done.

## Configuration
- AES192_KS_FWD_EN
  - When defined, adds input port fwd (1 bit, sampled with start).
  - fwd=1 streams keys in round order 0..12; rk_last is set at r==12.
  - fwd=0 streams in reverse order, as described above.
  - When undefined, the port is absent and streaming is always reverse.
  - Latency is identical in both modes.

## Test plan
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1:
  - First key out has rk_index=12 and rk_out=e98ba06f448c773c8ecc720401002202.
  - Last key has rk_index=0, rk_out=8e73b0f7da0e6452c810f32b809079e5 and rk_last=1.
  - done follows one cycle later.
- Key 000102030405060708090a0b0c0d0e0f1011121314151617:
  - First rk_out = a4970a331a78dc09c418c271e3a41d5d.
  - First rk_valid occurs exactly 47 cycles after start is accepted.
- Backpressure: drive rk_ready with a 1-of-3 duty pattern.
  - rk_out is held stable while stalled.
  - All 13 keys arrive in order 12..0 with no duplicates or drops.
- Assert start while busy (during EXPAND and during STREAM).
  - The start is ignored; the output stream is unchanged.
- Assert reset at cycle 20 of EXPAND, then start again with a different key.
  - Outputs are 0 after reset; no done pulse for the aborted run.
  - The new key streams correctly.
- With AES192_KS_FWD_EN defined and fwd=1, using the A.2 key:
  - First key out is rk_index=0 with rk_out=8e73b0f7da0e6452c810f32b809079e5.
  - Last key out is rk_index=12 with rk_last=1.

Source files
------------

// File: rtl/aes192_key_sched_rev_if.sv
// Start/key request and round-key valid/ready stream of the AES-192 key scheduler.
// The fwd direction select exists only when AES192_KS_FWD_EN is defined.
interface aes192_key_sched_rev_if;
   logic         start;
   logic [191:0] key_in;
`ifdef AES192_KS_FWD_EN
   logic         fwd;
`endif
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_index;
   logic         rk_last;
   logic         done;

   modport master (
`ifdef AES192_KS_FWD_EN
      output fwd,
`endif
      output start, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_index, rk_last, done
   );

   modport slave (
`ifdef AES192_KS_FWD_EN
      input  fwd,
`endif
      input  start, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_index, rk_last, done
   );
endinterface

// File: rtl/aes192_key_sched_rev.sv
// Iterative AES-192 key expansion (one word per cycle) streaming round keys 12..0.
// Define AES192_KS_FWD_EN to add a fwd input selecting round order 0..12 instead.
module aes192_key_sched_rev_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
   function automatic logic [7:0] sbox_f(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] b;
      sq = a;
      b  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         b  = gf_mul(b, sq);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   always_comb s_o = sbox_f(a_i);
endmodule

module aes192_key_sched_rev (
   input logic                   clk,
   input logic                   reset,
   aes192_key_sched_rev_if.slave ks
);
   typedef enum logic [1:0] {IDLE, EXPAND, STREAM, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] win_q [0:5];
   logic [31:0] win_d [0:5];
   logic [5:0]  i_q, i_d;
   logic [2:0]  phase_q, phase_d;
   logic [7:0]  rcon_q, rcon_d;
   logic [3:0]  r_q, r_d;
   logic        fwd_q, fwd_d;

   logic        fwd_in;
   logic [31:0] rot_word, sub_word, temp_word, new_word;
   logic [31:0] byp_word [0:3];
   logic        stream_end;
   logic [3:0]  r_step;
   logic        rd_en, rd_bypass;
   logic [3:0]  rd_row;
   logic [5:0]  old_idx;

`ifdef AES192_KS_FWD_EN
   assign fwd_in = ks.fwd;
`else
   assign fwd_in = 1'b0;
`endif

   // win_q holds w[i-6..i-1]; win_q[5] is the most recent word.
   assign rot_word = {win_q[5][23:0], win_q[5][31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes192_key_sched_rev_sbox u_sbox (
            .a_i (rot_word[8*gi +: 8]),
            .s_o (sub_word[8*gi +: 8])
         );
      end
   endgenerate

   always_comb begin
      temp_word = win_q[5];
      if (phase_q == 3'd0) temp_word = sub_word ^ {rcon_q, 24'h000000};
      new_word = win_q[0] ^ temp_word;
   end

   assign stream_end = fwd_q ? (r_q == 4'd12) : (r_q == 4'd0);
   assign r_step     = fwd_q ? (r_q + 4'd1) : (r_q - 4'd1);
   assign old_idx    = i_q - 6'd6;

   // Round 12 is finished on the same edge as w[51], so it bypasses the buffer.
   assign byp_word[0] = win_q[3];
   assign byp_word[1] = win_q[4];
   assign byp_word[2] = win_q[5];
   assign byp_word[3] = new_word;

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      i_d         = i_q;
      phase_d     = phase_q;
      rcon_d      = rcon_q;
      r_d         = r_q;
      fwd_d       = fwd_q;
      rd_en       = 1'b0;
      rd_bypass   = 1'b0;
      rd_row      = r_step;
      ks.busy     = 1'b0;
      ks.rk_valid = 1'b0;
      ks.rk_last  = 1'b0;
      ks.done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (ks.start) begin
               for (int k = 0; k < 6; k++) win_d[k] = ks.key_in[191-32*k -: 32];
               i_d     = 6'd6;
               phase_d = 3'd0;
               rcon_d  = 8'h01;
               fwd_d   = fwd_in;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            ks.busy = 1'b1;
            for (int k = 0; k < 5; k++) win_d[k] = win_q[k+1];
            win_d[5] = new_word;
            i_d      = i_q + 6'd1;
            phase_d  = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0};
            if (i_q == 6'd51) begin
               state_d   = STREAM;
               r_d       = fwd_q ? 4'd0 : 4'd12;
               rd_en     = 1'b1;
               rd_bypass = ~fwd_q;
               rd_row    = 4'd0;
            end
         end
         STREAM: begin
            ks.busy     = 1'b1;
            ks.rk_valid = 1'b1;
            ks.rk_last  = stream_end;
            if (ks.rk_ready) begin
               if (stream_end) begin
                  state_d = DONE;
               end else begin
                  r_d    = r_step;
                  rd_en  = 1'b1;
                  rd_row = r_step;
               end
            end
         end
         DONE: begin
            ks.done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         for (int k = 0; k < 6; k++) win_q[k] <= '0;
         i_q     <= '0;
         phase_q <= '0;
         rcon_q  <= '0;
         r_q     <= '0;
         fwd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int k = 0; k < 6; k++) win_q[k] <= win_d[k];
         i_q     <= i_d;
         phase_q <= phase_d;
         rcon_q  <= rcon_d;
         r_q     <= r_d;
         fwd_q   <= fwd_d;
      end
   end

   assign ks.rk_index = r_q;

   // Word w[n] lives in lane n%4, row n/4. While expanding, each cycle stores the new
   // word and, for the first six steps, the key word leaving the window (other lane).
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [31:0] mem [0:12];
         logic [31:0] rd_word_q;
         logic        wr_new, wr_old;

         assign wr_new = (state_q == EXPAND) && (i_q[1:0] == 2'(gi));
         assign wr_old = (state_q == EXPAND) && (i_q < 6'd12) && (old_idx[1:0] == 2'(gi));

         always_ff @(posedge clk) begin
            if (wr_new) mem[i_q[5:2]] <= new_word;
            else if (wr_old) mem[old_idx[5:2]] <= win_q[0];
         end

         always_ff @(posedge clk) begin
            if (reset) rd_word_q <= '0;
            else if (rd_en) rd_word_q <= rd_bypass ? byp_word[gi] : mem[rd_row];
         end

         assign ks.rk_out[127-32*gi -: 32] = rd_word_q;
      end
   endgenerate
endmodule

// File: tb/tb_aes192_key_sched_rev.sv
// Directed bench for aes192_key_sched_rev: FIPS-197 keys, backpressure, busy-start, abort.
module tb_aes192_key_sched_rev;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes192_key_sched_rev_if ks();
   aes192_key_sched_rev dut (.clk(clk), .reset(reset), .ks(ks));

   localparam logic [191:0] KEY_A2  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [191:0] KEY_SEQ = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

   int           checks   = 0;
   int           failures = 0;
   logic [127:0] got_key [0:12];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},     128'(ks.busy),     128'd0);
      check({tag, "_rk_valid"}, 128'(ks.rk_valid), 128'd0);
      check({tag, "_rk_out"},   ks.rk_out,         128'd0);
      check({tag, "_rk_index"}, 128'(ks.rk_index), 128'd0);
      check({tag, "_rk_last"},  128'(ks.rk_last),  128'd0);
      check({tag, "_done"},     128'(ks.done),     128'd0);
   endtask

   // Starts an expansion and waits for the first rk_valid; optionally pulses start mid-EXPAND.
   task automatic start_op(input logic [191:0] key, input logic f, input int poke_at, output int lat);
      ks.start  = 1'b1;
      ks.key_in = key;
`ifdef AES192_KS_FWD_EN
      ks.fwd    = f;
`endif
      tick();
      ks.start = 1'b0;
      lat      = 1;
      check("busy_after_start", 128'(ks.busy), 128'd1);
      while (!ks.rk_valid && lat < 100) begin
         tick();
         lat++;
         ks.start = (lat == poke_at);
         if (lat == poke_at) ks.key_in = ~key;
      end
      ks.start = 1'b0;
   endtask

   task automatic collect(input logic f, input int mode, input bit poke);
      int           cyc;
      int           n;
      logic         held_v;
      logic [127:0] h_out;
      logic [3:0]   h_idx;
      logic         h_last;
      cyc    = 0;
      n      = 0;
      held_v = 1'b0;
      h_out  = '0;
      h_idx  = '0;
      h_last = 1'b0;
      for (int k = 0; k < 13; k++) got_key[k] = '0;
      while (n < 13 && cyc < 200) begin
         ks.rk_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
         ks.start    = poke && (cyc < 3);
         if (held_v) begin
            check("stall_valid", 128'(ks.rk_valid), 128'd1);
            check("stall_out",   ks.rk_out,         h_out);
            check("stall_index", 128'(ks.rk_index), 128'(h_idx));
            check("stall_last",  128'(ks.rk_last),  128'(h_last));
         end
         if (ks.rk_valid && ks.rk_ready) begin
            $display("beat %0d idx=%0d last=%0b key=%h", n, ks.rk_index, ks.rk_last, ks.rk_out);
            check("beat_index", 128'(ks.rk_index), f ? 128'(n) : 128'(12 - n));
            check("beat_last",  128'(ks.rk_last),  128'(n == 12));
            if (ks.rk_index <= 4'd12) got_key[ks.rk_index] = ks.rk_out;
            n++;
            held_v = 1'b0;
         end else begin
            held_v = ks.rk_valid;
            h_out  = ks.rk_out;
            h_idx  = ks.rk_index;
            h_last = ks.rk_last;
         end
         tick();
         cyc++;
      end
      ks.rk_ready = 1'b0;
      ks.start    = 1'b0;
      check("beat_count", 128'(n), 128'd13);
      if (mode == 0) check("stream_cycles", 128'(cyc), 128'd13);
      check("done_pulse",    128'(ks.done),     128'd1);
      check("busy_at_done",  128'(ks.busy),     128'd0);
      check("valid_at_done", 128'(ks.rk_valid), 128'd0);
      tick();
      check("done_cleared", 128'(ks.done), 128'd0);
   endtask

   task automatic run(input logic [191:0] key, input logic f, input int mode,
                      input int poke_at, input bit poke_stream);
      int lat;
      start_op(key, f, poke_at, lat);
      check("first_valid_latency", 128'(lat), 128'd47);
      collect(f, mode, poke_stream);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   quiet_cyc;
      logic noisy;
      reset       = 1'b1;
      ks.start    = 1'b0;
      ks.key_in   = '0;
      ks.rk_ready = 1'b0;
`ifdef AES192_KS_FWD_EN
      ks.fwd      = 1'b0;
`endif
      tick();
      tick();
      reset = 1'b0;
      check_idle_outputs("reset");

      run(KEY_A2, 1'b0, 0, -1, 1'b0);
      check("a2_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
      check("a2_rk0",  got_key[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
      check("a2_rk1",  got_key[1],  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      check("a2_rk2",  got_key[2],  128'hec12068e6c827f6b0e7a95b95c56fec2);

      run(KEY_SEQ, 1'b0, 0, -1, 1'b0);
      check("seq_rk12", got_key[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
      check("seq_rk0",  got_key[0],  128'h000102030405060708090a0b0c0d0e0f);
      check("seq_rk1",  got_key[1],  128'h10111213141516175846f2f95c43f4fe);

      run(KEY_A2, 1'b0, 1, -1, 1'b0);
      check("bp_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
      check("bp_rk0",  got_key[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
      check("bp_rk2",  got_key[2],  128'hec12068e6c827f6b0e7a95b95c56fec2);

      run(KEY_A2, 1'b0, 0, 10, 1'b1);
      check("busy_start_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
      check("busy_start_rk0",  got_key[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
      check("busy_start_rk1",  got_key[1],  128'h62f8ead2522c6b7bfe0c91f72402f5a5);

      ks.start  = 1'b1;
      ks.key_in = KEY_A2;
      tick();
      ks.start = 1'b0;
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("abort");
      noisy = 1'b0;
      for (quiet_cyc = 0; quiet_cyc < 60; quiet_cyc++) begin
         if (ks.done || ks.rk_valid) noisy = 1'b1;
         tick();
      end
      check("abort_quiet", 128'(noisy), 128'd0);
      run(KEY_SEQ, 1'b0, 0, -1, 1'b0);
      check("after_abort_rk12", got_key[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
      check("after_abort_rk0",  got_key[0],  128'h000102030405060708090a0b0c0d0e0f);

`ifdef AES192_KS_FWD_EN
      run(KEY_A2, 1'b1, 0, -1, 1'b0);
      check("fwd_rk0",  got_key[0],  128'h8e73b0f7da0e6452c810f32b809079e5);
      check("fwd_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
      run(KEY_A2, 1'b0, 0, -1, 1'b0);
      check("rev_again_rk12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
